// File: rtl/aes_io_pkg.sv
// Shared definitions for the AES byte-serial I/O blocks (input_interface, output_interface).
package aes_io_pkg;

  localparam int AES_DATA_W  = 8;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = AES_BLOCK_W / AES_DATA_W;
  localparam int AES_CNT_W   = 4;

  localparam logic [AES_CNT_W-1:0] AES_LAST_CNT = AES_CNT_W'(AES_BYTES - 1);

  typedef enum logic [1:0] {
    S_PT   = 2'd0,
    S_KEY  = 2'd1,
    S_FULL = 2'd2
  } io_state_e;

endpackage : aes_io_pkg

// File: rtl/aes_byte_shreg.sv
// Block-wide shift register: each enabled cycle shifts left by one byte, new byte enters the LSBs.
module aes_byte_shreg
  import aes_io_pkg::*;
#(
  parameter int DATA_W  = AES_DATA_W,
  parameter int BLOCK_W = AES_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic [DATA_W-1:0]  din,
  output logic [BLOCK_W-1:0] q
);

  // NOTE: this is a datapath register, but it is still reset because a cleared
  // block must be observable after reset; plain storage arrays would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (shift_en) begin
      // NOTE: non-blocking so every flop samples the pre-edge value of q.
      q <= {q[BLOCK_W-DATA_W-1:0], din};
    end
  end

endmodule : aes_byte_shreg

// File: rtl/input_interface.sv
// Byte-serial AES front end: gathers 16 plaintext + 16 key bytes, hands the block over with valid/ack.
// Optional feature macro: INPUT_KEY_REUSE_EN (adds key_reuse, lets a block skip the key load).
module input_interface
  import aes_io_pkg::*;
#(
  parameter int DATA_W  = AES_DATA_W,
  parameter int BLOCK_W = AES_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               data_valid,
  output logic               input_ready,
  output logic               byte_drop,
  output logic [BLOCK_W-1:0] plaintext,
  output logic [BLOCK_W-1:0] key,
  output logic               block_valid,
  input  logic               transformer_ack
`ifdef INPUT_KEY_REUSE_EN
  ,
  input  logic               key_reuse
`endif
);

  io_state_e            state, next_state;
  logic [AES_CNT_W-1:0] cnt;
  logic                 accept;
  logic                 last_byte;
  logic                 skip_key;
  logic                 pt_shift, key_shift;

`ifdef INPUT_KEY_REUSE_EN
  assign skip_key = key_reuse;
`else
  assign skip_key = 1'b0;
`endif

  assign accept    = data_valid && input_ready;
  assign last_byte = accept && (cnt == AES_LAST_CNT);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= S_PT;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    input_ready = 1'b0;
    block_valid = 1'b0;
    pt_shift    = 1'b0;
    key_shift   = 1'b0;
    unique case (state)
      S_PT: begin
        input_ready = 1'b1;
        pt_shift    = data_valid;
        if (last_byte) next_state = skip_key ? S_FULL : S_KEY;
      end
      S_KEY: begin
        input_ready = 1'b1;
        key_shift   = data_valid;
        if (last_byte) next_state = S_FULL;
      end
      S_FULL: begin
        block_valid = 1'b1;
        if (transformer_ack) next_state = S_PT;
      end
      default: next_state = S_PT;
    endcase
  end

  // The 4-bit counter wraps 15 -> 0 on its own at each section boundary.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt       <= '0;
      byte_drop <= 1'b0;
    end else begin
      if (accept) cnt <= cnt + 1'b1;
      byte_drop <= data_valid && !input_ready;
    end
  end

  aes_byte_shreg #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_pt_reg (
    .clk      (clk),
    .rst_n    (rst_),
    .shift_en (pt_shift),
    .din      (data_in),
    .q        (plaintext)
  );

  aes_byte_shreg #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_key_reg (
    .clk      (clk),
    .rst_n    (rst_),
    .shift_en (key_shift),
    .din      (data_in),
    .q        (key)
  );

endmodule : input_interface

// File: tb/tb_input_interface.sv
// Directed bench for input_interface: scoreboard of expected blocks, immediate-assertion checks.
module tb_input_interface;
  import aes_io_pkg::*;

  localparam logic [127:0] FIPS_PT  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] FIPS_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] SEQ_PT   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] SEQ_KEY  = 128'h101112131415161718191A1B1C1D1E1F;

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic [7:0]   data_in = '0;
  logic         data_valid = 1'b0;
  logic         transformer_ack = 1'b0;
  logic         input_ready, byte_drop, block_valid;
  logic [127:0] plaintext, key;
`ifdef INPUT_KEY_REUSE_EN
  logic         key_reuse = 1'b0;
`endif

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
  } blk_t;

  blk_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  input_interface dut (
    .clk             (clk),
    .rst_            (rst_),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .input_ready     (input_ready),
    .byte_drop       (byte_drop),
    .plaintext       (plaintext),
    .key             (key),
    .block_valid     (block_valid),
    .transformer_ack (transformer_ack)
`ifdef INPUT_KEY_REUSE_EN
    ,
    .key_reuse       (key_reuse)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  // Sends bytes lo..hi of v, byte 0 being bits [127:120].
  task automatic send_range(input logic [127:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(v[127-8*i -: 8]);
  endtask

  task automatic load_block(input logic [127:0] pt, input logic [127:0] k);
    blk_t e;
    e.pt  = pt;
    e.key = k;
    sb.push_back(e);
    send_range(pt, 0, 15);
    check("valid_after_pt", 128'(block_valid), 128'd0);
    send_range(k, 0, 14);
    check("valid_after_31", 128'(block_valid), 128'd0);
    send(k[7:0]);
    check("valid_on_32nd", 128'(block_valid), 128'd1);
  endtask

  task automatic expect_block(input string tag);
    blk_t e;
    int   w = 0;
    while (!block_valid && w < 40) begin
      step();
      w++;
    end
    if (!block_valid) begin
      check({tag, "_timeout"}, 128'(block_valid), 128'd1);
    end else if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 128'(sb.size()), 128'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_pt"}, plaintext, e.pt);
      check({tag, "_key"}, key, e.key);
      check({tag, "_ready"}, 128'(input_ready), 128'd0);
    end
  endtask

  task automatic ack();
    transformer_ack = 1'b1;
    step();
    transformer_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;

    // Reset held for two cycles.
    step();
    step();
    check("rst_pt", plaintext, 128'd0);
    check("rst_key", key, 128'd0);
    check("rst_valid", 128'(block_valid), 128'd0);
    check("rst_drop", 128'(byte_drop), 128'd0);
    @(negedge clk);
    rst_ = 1'b1;
    step();
    check("rst_ready", 128'(input_ready), 128'd1);

    // FIPS-197 vector, back to back.
    load_block(FIPS_PT, FIPS_KEY);
    expect_block("fips");

    // Backpressure: five dropped bytes while the block is held.
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      data_in    = 8'hFF;
      data_valid = 1'b1;
      step();
      if (byte_drop) drops++;
    end
    data_valid = 1'b0;
    check("bp_drops", 128'(drops), 128'd5);
    check("bp_valid_held", 128'(block_valid), 128'd1);
    check("bp_pt", plaintext, FIPS_PT);
    check("bp_key", key, FIPS_KEY);
    ack();
    check("ack_ready", 128'(input_ready), 128'd1);
    check("ack_valid", 128'(block_valid), 128'd0);
    check("ack_drop_clear", 128'(byte_drop), 128'd0);
    check("ack_pt_kept", plaintext, FIPS_PT);

    // Spurious ack in S_PT after 7 bytes must not disturb the count.
    begin
      blk_t e;
      e.pt  = SEQ_PT;
      e.key = SEQ_KEY;
      sb.push_back(e);
    end
    send_range(SEQ_PT, 0, 6);
    ack();
    check("spur_valid", 128'(block_valid), 128'd0);
    check("spur_ready", 128'(input_ready), 128'd1);
    send_range(SEQ_PT, 7, 7);
    check("spur_pt8", plaintext, {FIPS_PT[63:0], SEQ_PT[127:64]});
    send_range(SEQ_PT, 8, 15);
    check("spur_valid_pt", 128'(block_valid), 128'd0);
    send_range(SEQ_KEY, 0, 14);
    check("spur_valid_31", 128'(block_valid), 128'd0);
    send(SEQ_KEY[7:0]);
    check("spur_valid_32", 128'(block_valid), 128'd1);
    expect_block("spur");

    // Ack and a byte in the same S_FULL cycle: ack wins, byte dropped.
    data_in         = 8'hAA;
    data_valid      = 1'b1;
    transformer_ack = 1'b1;
    step();
    data_valid      = 1'b0;
    transformer_ack = 1'b0;
    check("both_valid", 128'(block_valid), 128'd0);
    check("both_ready", 128'(input_ready), 128'd1);
    check("both_drop", 128'(byte_drop), 128'd1);
    check("both_pt", plaintext, SEQ_PT);
    step();
    check("both_drop_end", 128'(byte_drop), 128'd0);

    // Reset in the middle of a block discards the partial bytes.
    send_range(FIPS_PT, 0, 9);
    @(negedge clk);
    rst_ = 1'b0;
    @(negedge clk);
    check("midrst_pt", plaintext, 128'd0);
    check("midrst_valid", 128'(block_valid), 128'd0);
    rst_ = 1'b1;
    load_block(FIPS_PT, FIPS_KEY);
    expect_block("midrst");
    ack();

`ifdef INPUT_KEY_REUSE_EN
    // Key reuse: 16 plaintext bytes only, key retained.
    begin
      blk_t e;
      e.pt  = SEQ_PT;
      e.key = FIPS_KEY;
      sb.push_back(e);
    end
    key_reuse = 1'b1;
    send_range(SEQ_PT, 0, 14);
    check("reuse_valid_15", 128'(block_valid), 128'd0);
    send(SEQ_PT[7:0]);
    key_reuse = 1'b0;
    check("reuse_valid_16", 128'(block_valid), 128'd1);
    expect_block("reuse");
    ack();
`endif

    check("final_sb_empty", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_input_interface
